// File: rtl/controle_jogo.sv
// Round controller for the two-player prize game: countdown, prize window and
// result phase, with press arbitration and saturating per-player scores.
module controle_jogo #(
    parameter int STEP_TICKS = 4,
    parameter int WAIT_TICKS = 8,
    parameter int MAX_SCORE  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       b1,
    input  logic       b2,
    output logic [0:3] state_f,
    output logic [0:1] premio_f,
    output logic [0:4] p1_f,
    output logic [0:4] p2_f
);

    typedef enum logic [3:0] {
        S0  = 4'd0,
        S1  = 4'd1,
        S2  = 4'd2,
        S3  = 4'd3,
        S4  = 4'd4,
        SG1 = 4'd5,
        SG2 = 4'd6,
        SG0 = 4'd7,
        SGX = 4'd8
    } state_t;

    localparam int CNT_MAX = (STEP_TICKS > WAIT_TICKS) ? STEP_TICKS : WAIT_TICKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          start_prev, b1_prev, b2_prev;
    logic          start_press, b1_press, b2_press;
    logic          step_done, wait_done, game_over, timed;

    assign state_f = state;

    always_comb begin
        start_press = start & ~start_prev;
        b1_press    = b1 & ~b1_prev;
        b2_press    = b2 & ~b2_prev;
        step_done   = tick && (cnt == CW'(STEP_TICKS - 1));
        wait_done   = tick && (cnt == CW'(WAIT_TICKS - 1));
        game_over   = (p1_f == 5'(MAX_SCORE)) || (p2_f == 5'(MAX_SCORE));
        timed       = state inside {S1, S2, S3, S4, SGX};
    end

    // Presses take priority over an expiring timer in the same cycle.
    always_comb begin
        // NOTE: default assignment first so every path drives nxt and no latch is inferred.
        nxt = state;
        case (state)
            S0: if (start_press) nxt = S1;
            S1, S2, S3: begin
                if (b1_press && b2_press) nxt = SG0;
                else if (b1_press)        nxt = SG2;
                else if (b2_press)        nxt = SG1;
                else if (step_done)       nxt = (state == S1) ? S2 : (state == S2) ? S3 : S4;
            end
            S4: begin
                if (b1_press && b2_press) nxt = SG0;
                else if (b1_press)        nxt = SG1;
                else if (b2_press)        nxt = SG2;
                else if (wait_done)       nxt = SG0;
            end
            SG1, SG2, SG0: nxt = SGX;
            SGX: if (wait_done) nxt = game_over ? S0 : S1;
            default: nxt = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S0;
            premio_f   <= 2'b00;
            p1_f       <= '0;
            p2_f       <= '0;
            cnt        <= '0;
            // Start high so a button held through reset release is not a press.
            start_prev <= 1'b1;
            b1_prev    <= 1'b1;
            b2_prev    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            start_prev <= start;
            b1_prev    <= b1;
            b2_prev    <= b2;
            state      <= nxt;
            if (nxt != state) begin
                cnt <= '0;
                case (nxt)
                    S1: if (state == S0) begin
                        p1_f     <= '0;
                        p2_f     <= '0;
                        premio_f <= 2'b00;
                    end
                    SG1: begin
                        if (p1_f < 5'(MAX_SCORE)) p1_f <= p1_f + 5'd1;
                        premio_f <= 2'b01;
                    end
                    SG2: begin
                        if (p2_f < 5'(MAX_SCORE)) p2_f <= p2_f + 5'd1;
                        premio_f <= 2'b10;
                    end
                    SG0: premio_f <= 2'b00;
                    default: ;
                endcase
            end else if (tick && timed) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo with STEP_TICKS=2, WAIT_TICKS=3, MAX_SCORE=9
// and tick held high, so every duration is counted in clock cycles.
module tb_controle_jogo;

    logic       clk = 1'b0;
    logic       reset, tick, start, b1, b2;
    logic [0:3] state_f;
    logic [0:1] premio_f;
    logic [0:4] p1_f, p2_f;

    int n_checks = 0;
    int n_pass   = 0;

    controle_jogo #(.STEP_TICKS(2), .WAIT_TICKS(3), .MAX_SCORE(9)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .b1(b1), .b2(b2),
        .state_f(state_f), .premio_f(premio_f), .p1_f(p1_f), .p2_f(p2_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input int code, input int budget);
        for (int i = 0; i < budget && int'(state_f) != code; i++) cyc(1);
        check(tag, int'(state_f), code);
    endtask

    task automatic check_all(input string tag, input int st, input int pr, input int s1, input int s2);
        check({tag, "_state"},  int'(state_f),  st);
        check({tag, "_premio"}, int'(premio_f), pr);
        check({tag, "_p1"},     int'(p1_f),     s1);
        check({tag, "_p2"},     int'(p2_f),     s2);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; start = 1'b1; b1 = 1'b1; b2 = 1'b0;

        // 1. Reset with b1 and start held; neither counts as a press on release.
        cyc(3);
        check_all("rst", 0, 0, 0, 0);
        reset = 1'b0;
        cyc(3);
        check_all("rst_held", 0, 0, 0, 0);
        start = 1'b0; b1 = 1'b0;
        cyc(1);

        // 2. Normal round.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_all("start", 1, 0, 0, 0);
        cyc(1); check("s1_c2", int'(state_f), 1);
        cyc(1); check("s2_c1", int'(state_f), 2);
        cyc(1); check("s2_c2", int'(state_f), 2);
        cyc(1); check("s3_c1", int'(state_f), 3);
        cyc(1); check("s3_c2", int'(state_f), 3);
        cyc(1); check("s4_c1", int'(state_f), 4);
        cyc(1); check("s4_c2", int'(state_f), 4);
        b1 = 1'b1;
        cyc(1);
        b1 = 1'b0;
        check_all("win1", 5, 1, 1, 0);
        cyc(1); check_all("sgx_c1", 8, 1, 1, 0);
        cyc(1); check("sgx_c2", int'(state_f), 8);
        cyc(1); check("sgx_c3", int'(state_f), 8);
        cyc(1); check_all("next_s1", 1, 1, 1, 0);

        // 3. False start: b2 during s2 awards player 1.
        wait_state("to_s2", 2, 10);
        b2 = 1'b1;
        cyc(1);
        b2 = 1'b0;
        check_all("false_b2", 5, 1, 2, 0);

        // 4a. Timeout in s4.
        wait_state("to_s4_a", 4, 20);
        cyc(2); check("s4_hold", int'(state_f), 4);
        cyc(1); check_all("timeout", 7, 0, 2, 0);
        cyc(1); check("timeout_sgx", int'(state_f), 8);

        // 4b. Tie in s4.
        wait_state("to_s4_b", 4, 20);
        b1 = 1'b1; b2 = 1'b1;
        cyc(1);
        b1 = 1'b0; b2 = 1'b0;
        check_all("tie", 7, 0, 2, 0);

        // 5. Drive player 1 to the maximum and the game ends.
        for (int k = 3; k <= 9; k++) begin
            wait_state($sformatf("to_s4_w%0d", k), 4, 20);
            b1 = 1'b1;
            cyc(1);
            b1 = 1'b0;
            check($sformatf("p1_w%0d", k), int'(p1_f), k);
        end
        cyc(1); check("final_sgx", int'(state_f), 8);
        cyc(3); check_all("game_over", 0, 1, 9, 0);
        cyc(2); check("idle_stays", int'(state_f), 0);
        b1 = 1'b1;
        cyc(1);
        b1 = 1'b0;
        check_all("b1_in_s0", 0, 1, 9, 0);
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_all("restart", 1, 0, 0, 0);

        // 6. Player 2 reaches 4, then reset during s3 acts without a clock edge.
        for (int k = 1; k <= 4; k++) begin
            wait_state($sformatf("to_s4_p2_%0d", k), 4, 20);
            b2 = 1'b1;
            cyc(1);
            b2 = 1'b0;
            check($sformatf("p2_w%0d", k), int'(p2_f), k);
        end
        wait_state("to_s3", 3, 20);
        check("p2_before_rst", int'(p2_f), 4);
        #2 reset = 1'b1;
        #1 check_all("async_rst", 0, 0, 0, 0);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        check_all("post_rst", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/controle_jogo.md
# controle_jogo

Game-round controller for the two-player prize game. It sequences each round through a countdown, an open prize window and a result phase, and resolves button presses into a winner. It keeps both players' scores and drives `state_f`, `premio_f`, `p1_f` and `p2_f` directly into the display stage, which decodes them to seven-segment digits and LEDs.

## Interface
Parameters:
- `STEP_TICKS`, default 4: ticks spent in each countdown state s1, s2, s3.
- `WAIT_TICKS`, default 8: ticks of the s4 prize window, and also of the sgx result hold.
- `MAX_SCORE`, default 9: score at which the game ends; scores saturate here.

Ports:
- `clk`, in, 1: system clock; the single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: one-cycle time-base enable; all durations are counted in ticks.
- `start`, in, 1: start button, level, already synchronous to `clk`.
- `b1`, in, 1: player 1 button, level, synchronous.
- `b2`, in, 1: player 2 button, level, synchronous.
- `state_f`, out, [0:3]: current state code (s0=0000, s1=0001, s2=0010, s3=0011, s4=0100, sg1=0101, sg2=0110, sg0=0111, sgx=1000).
- `premio_f`, out, [0:1]: round result; 01 = player 1 won, 10 = player 2 won, 00 = none.
- `p1_f`, out, [0:4]: player 1 score, 0..MAX_SCORE.
- `p2_f`, out, [0:4]: player 2 score, 0..MAX_SCORE.

## Operation
- All outputs are registered.
- **Reset values:** `state_f`=0000, `premio_f`=00, `p1_f`=0, `p2_f`=0, tick counter 0.
- **Edge detection:** a press is `x & ~x_prev`, where `x_prev` is registered. The `*_prev` registers reset to 1, so a button held through reset release is not a press.
- **Tick counter:** cleared on every state change. A timed state exits on the cycle where `tick`=1 and count = N-1, so it lasts exactly N ticks.
- **s0 (idle):** a `start` press clears `p1_f`/`p2_f` to 0 and `premio_f` to 00, then goes to s1. `b1`/`b2` are ignored.
- **s1, s2, s3 (countdown):** after STEP_TICKS ticks, go to the next state (s3 goes to s4).
  - A press during the countdown is a false start and awards the opponent.
  - b1 press only: go to sg2.
  - b2 press only: go to sg1.
  - Both in the same cycle: go to sg0.
- **s4 (prize window):**
  - b1 press only: go to sg1.
  - b2 press only: go to sg2.
  - Both in the same cycle: go to sg0.
  - WAIT_TICKS elapsed with no press: go to sg0.
  - A press and the timeout in the same cycle: the press wins.
- **Entering sg1:** `p1_f` +1, saturating at MAX_SCORE; `premio_f`=01. Score, `premio_f` and `state_f` update on the same edge.
- **Entering sg2:** `p2_f` +1, saturating; `premio_f`=10.
- **Entering sg0:** `premio_f`=00; scores unchanged.
- **sg1, sg2, sg0** each last exactly one `clk` cycle, independent of `tick`, then go to sgx.
- **sgx:** holds `premio_f` for WAIT_TICKS ticks. It then goes to s0 if either score equals MAX_SCORE, otherwise to s1.
- `start` is ignored in every state except s0.

## Timing
- **Button to state:** a button first sampled high at edge k produces the new `state_f` (and score) after edge k. Latency is 1 cycle.
- **Countdown:** s1 through s3 total 3·STEP_TICKS ticks; s4 is at most WAIT_TICKS ticks.
- **Result phase:** sg* lasts 1 cycle; sgx lasts WAIT_TICKS ticks.
- **Holding vs. pressing:** a button held high counts once. A second press needs a low cycle in between.
- **Reset mid-operation:** the asynchronous reset forces every output to its reset value immediately, independent of `clk`.

## Test plan
All scenarios use STEP_TICKS=2, WAIT_TICKS=3, MAX_SCORE=9 and `tick`=1 every cycle.

1. **Reset:** assert `reset` with `b1`=1 held, then release. Required: outputs 0000/00/0/0, and the state stays s0 with no press registered.
2. **Normal round:** `start` pulse, then `b1` pulse in the 2nd cycle of s4. Required:
   - s1, s2, s3 each last 2 cycles.
   - After the `b1` edge: `state_f`=0101, `p1_f`=1, `premio_f`=01.
   - One cycle later: `state_f`=1000 for 3 cycles, then 0001.
3. **False start:** `b2` press during s2. Required: next state 0110? No: next state is sg1 (0101), `p1_f` +1, `premio_f`=01.
4. **Timeout and tie:**
   - No press in s4: after 3 cycles, `state_f`=0111, `premio_f`=00, scores unchanged.
   - Next round, `b1` and `b2` pressed in the same s4 cycle: sg0, no score change.
5. **Saturation and game over:** `p1_f` reaches 9. Required:
   - After sgx the state goes to s0 and `p1_f` holds 9.
   - A `b1` press in s0 is ignored.
   - A `start` press clears both scores to 0 and enters s1.
6. **Reset mid-round:** assert `reset` during s3 with `p2_f`=4. Required: all outputs 0 immediately, without waiting for a clock edge.
